pipe_muxn: RTL and testbench

Parametrised, registered N:1 datapath multiplexer with a valid/ready handshake and a two-entry skid buffer, for the 32-bit pipelined processor's operand-select and forwarding paths. It generalises the clocked two-input 32-bit mux to any data width and input count. It adds:
- back-pressure, so a stalled downstream stage never loses or duplicates a word;
- a synchronous pipeline flush;
- out-of-range select detection;
- a delivered-transfer counter for performance monitoring.

---
 rtl/pipe_muxn_if.sv | 39 +++
 rtl/pipe_muxn.sv | 169 ++++++++++++++++
 tb/tb_pipe_muxn.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_muxn_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_muxn_if
//  Purpose  : Handshake/bus bundle for pipe_muxn. Groups the packed input
//             channels, the select, the valid/ready pairs on both sides, the
//             flush strobe and the status outputs (sel_err, xfer_cnt).
//  Modports : master - the side that drives words in and takes them out
//             slave  - the pipe_muxn block itself
//  Revision : 1.0 - initial release
// ============================================================================
interface pipe_muxn_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;
    logic [15:0]             xfer_cnt;

    modport master (
        output in_data, sel, in_valid, flush, out_ready,
        input  in_ready, out_data, out_sel, out_valid, sel_err, xfer_cnt
    );

    modport slave (
        input  in_data, sel, in_valid, flush, out_ready,
        output in_ready, out_data, out_sel, out_valid, sel_err, xfer_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_muxn.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_muxn
//  Purpose  : Registered N:1 datapath multiplexer with valid/ready handshake
//             and a two-entry skid buffer (main register M feeds the output,
//             skid register S absorbs one word while downstream stalls).
//             Supports synchronous flush, out-of-range select detection and
//             a 16-bit delivered-word counter.
//  Ports    : clk    - rising-edge clock
//             rst_n  - asynchronous active-low reset
//             bus    - pipe_muxn_if.slave: in_data/sel/in_valid/in_ready,
//                      flush, out_data/out_sel/out_valid/out_ready,
//                      sel_err, xfer_cnt
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_muxn #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    pipe_muxn_if.slave  bus
);
    localparam int SEL_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int c_CNT_W = 16;

    // Encoding is {S.valid, M.valid}; 2'b10 cannot be reached because S only
    // fills while M is already holding a word.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_m_data;
    logic [SEL_W-1:0]   r_m_sel;
    logic [WIDTH-1:0]   r_s_data;
    logic [SEL_W-1:0]   r_s_sel;
    logic               r_sel_err;
    logic [c_CNT_W-1:0] r_xfer_cnt;

    logic [WIDTH-1:0]   w_chan [NUM_IN];
    logic [WIDTH-1:0]   w_sel_data;
    logic               w_sel_oob;
    logic               w_m_valid;
    logic               w_s_valid;
    logic               w_accept;
    logic               w_deliver;
    logic               w_load_m_new;
    logic               w_load_m_skid;
    logic               w_load_s_new;

    // ------------------------------------------------------------------
    // Input channel selection
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < NUM_IN; k++) begin : g_chan
            assign w_chan[k] = bus.in_data[k*WIDTH +: WIDTH];
        end
    endgenerate

    // A select with no matching channel leaves the default of zero, which
    // is exactly the data stored for an out-of-range select.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (bus.sel == SEL_W'(k)) begin
                w_sel_data = w_chan[k];
            end
        end
    end

    // One extra bit so NUM_IN itself is representable for the compare.
    assign w_sel_oob = ({1'b0, bus.sel} >= (SEL_W+1)'(NUM_IN));

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign w_m_valid = r_state[0];
    assign w_s_valid = r_state[1];

    // in_ready depends only on the skid valid bit, so out_ready never
    // reaches in_ready combinationally.
    assign w_accept  = bus.in_valid && !w_s_valid;
    assign w_deliver = w_m_valid && bus.out_ready;

    assign w_load_m_new  = w_accept && (!w_m_valid || w_deliver);
    assign w_load_s_new  = w_accept && w_m_valid && !w_deliver;
    assign w_load_m_skid = w_deliver && w_s_valid;

    // ------------------------------------------------------------------
    // Control state, error pulse and transfer counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_sel_err  <= 1'b0;
            r_xfer_cnt <= '0;
        end else begin
            // A word accepted in a flush cycle is discarded and never flagged.
            r_sel_err <= w_accept && w_sel_oob && !bus.flush;

            // A delivery in a flush cycle still counts: downstream took it.
            if (w_deliver) begin
                r_xfer_cnt <= r_xfer_cnt + c_CNT_W'(1);
            end

            if (bus.flush) begin
                r_state <= EMPTY;
            end else begin
                case (r_state)
                    EMPTY: begin
                        if (w_accept) begin
                            r_state <= ONE;
                        end
                    end
                    ONE: begin
                        if (w_accept && !w_deliver) begin
                            r_state <= FULL;
                        end else if (!w_accept && w_deliver) begin
                            r_state <= EMPTY;
                        end
                    end
                    FULL: begin
                        // in_ready is low here, so only a delivery can occur.
                        if (w_deliver) begin
                            r_state <= ONE;
                        end
                    end
                    default: r_state <= EMPTY;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Data registers (no reset; qualified by the valid bits above)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_load_m_new) begin
            r_m_data <= w_sel_data;
            r_m_sel  <= bus.sel;
        end else if (w_load_m_skid) begin
            r_m_data <= r_s_data;
            r_m_sel  <= r_s_sel;
        end

        if (w_load_s_new) begin
            r_s_data <= w_sel_data;
            r_s_sel  <= bus.sel;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The data registers carry no reset, so the output word and select are
    // forced to zero whenever M is empty; this also gives zeros while rst_n
    // is held low.
    assign bus.out_data  = w_m_valid ? r_m_data : '0;
    assign bus.out_sel   = w_m_valid ? r_m_sel  : '0;
    assign bus.out_valid = w_m_valid;
    assign bus.in_ready  = !w_s_valid;
    assign bus.sel_err   = r_sel_err;
    assign bus.xfer_cnt  = r_xfer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_muxn.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_muxn
//  Purpose  : Self-checking bench for pipe_muxn. Instance A (WIDTH=32,
//             NUM_IN=4) covers streaming, back-pressure, flush, async reset
//             and counter wrap through a scoreboard queue; instance B
//             (WIDTH=8, NUM_IN=3) covers out-of-range select handling.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_muxn;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    pipe_muxn_if #(.WIDTH(32), .NUM_IN(4)) bus_a ();
    pipe_muxn_if #(.WIDTH(8),  .NUM_IN(3)) bus_b ();

    pipe_muxn #(.WIDTH(32), .NUM_IN(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    pipe_muxn #(.WIDTH(8), .NUM_IN(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    typedef struct {
        logic [31:0] d;
        logic [1:0]  s;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cnt_a = 0;
    bit   acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of instance A. Inputs are sampled at the falling edge (they
    // are stable until the next rising edge); a delivery pops and compares,
    // an accept pushes the word the bench itself offered.
    task automatic tick_a(output bit acc_o);
        bit          del;
        exp_t        e;
        logic [31:0] word;
        @(negedge clk);
        acc_o = bus_a.in_valid && bus_a.in_ready;
        del   = bus_a.out_valid && bus_a.out_ready;
        if (del) begin
            cnt_a++;
            chk("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("sb_data", 64'(bus_a.out_data), 64'(e.d));
                chk("sb_sel",  64'(bus_a.out_sel),  64'(e.s));
            end
        end
        if (bus_a.flush) begin
            sbq.delete();
        end else if (acc_o) begin
            word = bus_a.in_data[32*bus_a.sel +: 32];
            sbq.push_back('{d: word, s: bus_a.sel});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus_a.in_data = '0; bus_a.sel = '0; bus_a.in_valid = 1'b0;
        bus_a.flush = 1'b0; bus_a.out_ready = 1'b0;
        bus_b.in_data = '0; bus_b.sel = '0; bus_b.in_valid = 1'b0;
        bus_b.flush = 1'b0; bus_b.out_ready = 1'b0;

        // ---------------- reset state ----------------
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus_a.in_ready),  64'd1);
        chk("rst_sel_err",   64'(bus_a.sel_err),   64'd0);
        chk("rst_xfer_cnt",  64'(bus_a.xfer_cnt),  64'd0);
        chk("rst_out_data",  64'(bus_a.out_data),  64'd0);
        chk("rst_out_sel",   64'(bus_a.out_sel),   64'd0);
        chk("rst_b_valid",   64'(bus_b.out_valid), 64'd0);
        rst_n = 1'b1;

        // ---------------- streaming ----------------
        bus_a.in_data   = {32'h44, 32'h33, 32'h22, 32'h11};
        bus_a.out_ready = 1'b1;
        bus_a.in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus_a.sel = 2'(k);
            tick_a(acc);
            chk("stream_valid", 64'(bus_a.out_valid), 64'd1);
            chk("stream_data",  64'(bus_a.out_data),  64'(32'h11 * (k + 1)));
        end
        bus_a.in_valid = 1'b0;
        tick_a(acc);
        chk("stream_cnt",   64'(bus_a.xfer_cnt),  64'd4);
        chk("stream_empty", 64'(bus_a.out_valid), 64'd0);

        // ---------------- back-pressure ----------------
        bus_a.out_ready = 1'b0;
        bus_a.in_valid  = 1'b1;
        bus_a.sel       = 2'd0;
        bus_a.in_data   = {32'h0, 32'h0, 32'h0, 32'hA1};
        tick_a(acc);
        chk("bp_ready_one", 64'(bus_a.in_ready), 64'd1);
        bus_a.in_data   = {32'h0, 32'h0, 32'h0, 32'hA2};
        tick_a(acc);
        chk("bp_ready_full", 64'(bus_a.in_ready), 64'd0);
        chk("bp_hold_data",  64'(bus_a.out_data), 64'h0A1);
        bus_a.in_data   = {32'h0, 32'h0, 32'h0, 32'hA3};
        tick_a(acc);
        chk("bp_third_held", 64'(acc), 64'd0);
        chk("bp_still_full", 64'(bus_a.in_ready), 64'd0);
        bus_a.out_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick_a(acc);
            if (acc) bus_a.in_valid = 1'b0;
        end
        chk("bp_drained", 64'(sbq.size()), 64'd0);
        chk("bp_cnt",     64'(bus_a.xfer_cnt), 64'd7);

        // ---------------- flush in FULL with in_valid ----------------
        bus_a.out_ready = 1'b0;
        bus_a.in_valid  = 1'b1;
        bus_a.in_data   = {32'h0, 32'h0, 32'h0, 32'hB1};
        tick_a(acc);
        bus_a.in_data   = {32'h0, 32'h0, 32'h0, 32'hB2};
        tick_a(acc);
        bus_a.in_data   = {32'h0, 32'h0, 32'h0, 32'hB3};
        bus_a.flush     = 1'b1;
        tick_a(acc);
        bus_a.flush     = 1'b0;
        bus_a.in_valid  = 1'b0;
        chk("flush_valid", 64'(bus_a.out_valid), 64'd0);
        chk("flush_ready", 64'(bus_a.in_ready),  64'd1);
        chk("flush_cnt",   64'(bus_a.xfer_cnt),  64'd7);
        bus_a.out_ready = 1'b1;
        tick_a(acc);
        tick_a(acc);
        chk("flush_no_ghost", 64'(bus_a.out_valid), 64'd0);

        // flush in ONE with a delivery and an accept in the same cycle
        bus_a.out_ready = 1'b0;
        bus_a.in_valid  = 1'b1;
        bus_a.in_data   = {32'h0, 32'h0, 32'h0, 32'hC1};
        tick_a(acc);
        bus_a.out_ready = 1'b1;
        bus_a.flush     = 1'b1;
        bus_a.in_data   = {32'h0, 32'h0, 32'h0, 32'hC2};
        tick_a(acc);
        bus_a.flush     = 1'b0;
        bus_a.in_valid  = 1'b0;
        chk("flush1_valid", 64'(bus_a.out_valid), 64'd0);
        chk("flush1_cnt",   64'(bus_a.xfer_cnt),  64'd8);
        tick_a(acc);
        chk("flush1_no_ghost", 64'(bus_a.out_valid), 64'd0);

        // ---------------- out-of-range select (NUM_IN=3) ----------------
        bus_b.in_data   = {8'h33, 8'h22, 8'h11};
        bus_b.sel       = 2'd3;
        bus_b.in_valid  = 1'b1;
        bus_b.out_ready = 1'b0;
        @(posedge clk); #1;
        chk("oob_valid", 64'(bus_b.out_valid), 64'd1);
        chk("oob_data",  64'(bus_b.out_data),  64'd0);
        chk("oob_sel",   64'(bus_b.out_sel),   64'd3);
        chk("oob_err",   64'(bus_b.sel_err),   64'd1);
        bus_b.in_valid  = 1'b0;
        @(posedge clk); #1;
        chk("oob_err_pulse", 64'(bus_b.sel_err),   64'd0);
        chk("oob_hold",      64'(bus_b.out_valid), 64'd1);
        bus_b.out_ready = 1'b1;
        bus_b.in_valid  = 1'b1;
        bus_b.sel       = 2'd2;
        @(posedge clk); #1;
        chk("b_ch2_data", 64'(bus_b.out_data), 64'h33);
        chk("b_ch2_sel",  64'(bus_b.out_sel),  64'd2);
        chk("b_ch2_err",  64'(bus_b.sel_err),  64'd0);
        chk("b_cnt1",     64'(bus_b.xfer_cnt), 64'd1);
        bus_b.sel       = 2'd3;
        bus_b.flush     = 1'b1;
        @(posedge clk); #1;
        chk("b_flush_err",   64'(bus_b.sel_err),   64'd0);
        chk("b_flush_valid", 64'(bus_b.out_valid), 64'd0);
        chk("b_flush_cnt",   64'(bus_b.xfer_cnt),  64'd2);
        bus_b.flush     = 1'b0;
        bus_b.in_valid  = 1'b0;

        // ---------------- async reset while FULL ----------------
        bus_a.out_ready = 1'b0;
        bus_a.in_valid  = 1'b1;
        bus_a.sel       = 2'd1;
        bus_a.in_data   = {32'h0, 32'h0, 32'hD1, 32'h0};
        tick_a(acc);
        bus_a.in_data   = {32'h0, 32'h0, 32'hD2, 32'h0};
        tick_a(acc);
        bus_a.in_valid  = 1'b0;
        chk("ar_full", 64'(bus_a.in_ready), 64'd0);
        #2;
        rst_n       = 1'b0;
        bus_a.flush = 1'b1;
        #1;
        chk("ar_out_valid", 64'(bus_a.out_valid), 64'd0);
        chk("ar_in_ready",  64'(bus_a.in_ready),  64'd1);
        chk("ar_xfer_cnt",  64'(bus_a.xfer_cnt),  64'd0);
        chk("ar_out_data",  64'(bus_a.out_data),  64'd0);
        chk("ar_out_sel",   64'(bus_a.out_sel),   64'd0);
        chk("ar_sel_err",   64'(bus_a.sel_err),   64'd0);
        @(posedge clk); #1;
        rst_n       = 1'b1;
        bus_a.flush = 1'b0;
        sbq.delete();
        cnt_a = 0;

        // ---------------- counter wrap ----------------
        bus_a.out_ready = 1'b1;
        bus_a.in_valid  = 1'b1;
        bus_a.sel       = 2'd2;
        for (int i = 0; i < 65536; i++) begin
            bus_a.in_data = {32'hDEADBEEF, 32'(i) ^ 32'h5A5A0000, 32'h0, 32'h0};
            tick_a(acc);
        end
        chk("wrap_ffff", 64'(bus_a.xfer_cnt), 64'hFFFF);
        bus_a.in_valid = 1'b0;
        tick_a(acc);
        chk("wrap_zero",  64'(bus_a.xfer_cnt),  64'h0000);
        chk("wrap_model", 64'(cnt_a),           64'd65536);
        chk("wrap_empty", 64'(bus_a.out_valid), 64'd0);
        chk("wrap_sb",    64'(sbq.size()),      64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
